// File: rtl/rv_pkg.sv
// Shared RISC-V immediate definitions used by the encoder and the extender.
package rv_pkg;

    // Immediate format select; same encoding as the extender.
    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } imm_src_t;

    // instr_hi carries instruction bits [31:7].
    localparam int unsigned INSTR_LSB = 7;
    localparam int unsigned HI_W      = 32 - INSTR_LSB;

    // Highest immediate bit that is still encoded (sign position) per format.
    localparam int unsigned I_SIGN_BIT = 11;
    localparam int unsigned S_SIGN_BIT = 11;
    localparam int unsigned B_SIGN_BIT = 12;
    localparam int unsigned J_SIGN_BIT = 20;

    // True when every bit of v from position msb upward equals v[msb],
    // i.e. v is representable as an (msb+1)-bit signed value.
    function automatic logic fits_signed(logic [31:0] v, int unsigned msb);
        logic signed [31:0] t;
        t = $signed(v) >>> msb;
        return (t == '0) || (t == '1);
    endfunction

endpackage

// File: rtl/imm_pack.sv
// Combinational packer: places a signed immediate into instruction bits
// [31:7] for the selected format and flags values the format cannot hold.
module imm_pack
    import rv_pkg::*;
(
    input  logic [1:0]  imm_src,
    input  logic [31:0] imm,
    input  logic [24:0] base,
    output logic [24:0] instr_hi,
    output logic        err
);

    // Instruction bits [31:25] always belong to the immediate in every format.
    logic unused_base;
    assign unused_base = ^base[24:18];

    // Field placement and range/alignment check per format.
    always_comb begin
        instr_hi = '0;
        err      = 1'b0;
        unique case (imm_src_t'(imm_src))
            IMM_I: begin
                instr_hi = {imm[11:0], base[12:0]};
                err      = !fits_signed(imm, I_SIGN_BIT);
            end
            IMM_S: begin
                instr_hi = {imm[11:5], base[17:5], imm[4:0]};
                err      = !fits_signed(imm, S_SIGN_BIT);
            end
            IMM_B: begin
                instr_hi = {imm[12], imm[10:5], base[17:5], imm[4:1], imm[11]};
                err      = !fits_signed(imm, B_SIGN_BIT) || imm[0];
            end
            IMM_J: begin
                instr_hi = {imm[20], imm[10:1], imm[11], imm[19:12], base[4:0]};
                err      = !fits_signed(imm, J_SIGN_BIT) || imm[0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/imm_encode.sv
// Two-stage valid/ready immediate encoder with full backpressure and a
// saturating count of delivered results that carried an immediate error.
module imm_encode
    import rv_pkg::*;
#(
    parameter int unsigned ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           imm_src,
    input  logic [31:0]          imm,
    input  logic [24:0]          base,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [24:0]          instr_hi,
    output logic                 imm_err,
    output logic [ERR_CNT_W-1:0] err_count
);

    logic                 s1_valid_q;
    logic [1:0]           s1_src_q;
    logic [31:0]          s1_imm_q;
    logic [24:0]          s1_base_q;
    logic                 s2_valid_q;
    logic [24:0]          s2_hi_q;
    logic                 s2_err_q;
    logic [ERR_CNT_W-1:0] err_cnt_q;

    logic                 adv1;
    logic                 adv2;
    logic [24:0]          pack_hi;
    logic                 pack_err;

    // Pipeline advance: each stage moves when the stage after it can take data.
    always_comb begin
        adv2     = !s2_valid_q || out_ready;
        adv1     = !s1_valid_q || adv2;
        in_ready = adv1;
    end

    imm_pack u_pack (
        .imm_src  (s1_src_q),
        .imm      (s1_imm_q),
        .base     (s1_base_q),
        .instr_hi (pack_hi),
        .err      (pack_err)
    );

    // Stage 1: capture the request on an input transfer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_src_q   <= '0;
            s1_imm_q   <= '0;
            s1_base_q  <= '0;
        end else if (adv1) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_src_q  <= imm_src;
                s1_imm_q  <= imm;
                s1_base_q <= base;
            end
        end
    end

    // Stage 2: register the packed result; held while the consumer stalls.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_valid_q <= 1'b0;
            s2_hi_q    <= '0;
            s2_err_q   <= 1'b0;
        end else if (adv2) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_hi_q  <= pack_hi;
                s2_err_q <= pack_err;
            end
        end
    end

    // Error counter: counts erroring output transfers, sticks at all-ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_cnt_q <= '0;
        end else if (s2_valid_q && out_ready && s2_err_q && (err_cnt_q != '1)) begin
            err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
        end
    end

    assign out_valid = s2_valid_q;
    assign instr_hi  = s2_hi_q;
    assign imm_err   = s2_err_q;
    assign err_count = err_cnt_q;

endmodule

// File: tb/tb_imm_encode.sv
// Self-checking bench for imm_encode: directed format cases, backpressure,
// reset with requests in flight, randomized streaming and counter saturation.
module tb_imm_encode;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  imm_src;
    logic [31:0] imm;
    logic [24:0] base;
    logic        out_valid;
    logic        out_ready;
    logic [24:0] instr_hi;
    logic        imm_err;
    logic [7:0]  err_count;

    int vectors = 0;
    int errors  = 0;
    int m_cnt   = 0;

    typedef struct packed {
        logic [24:0] hi;
        logic        err;
        logic [1:0]  src;
        logic [31:0] imm;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;

    imm_encode #(.ERR_CNT_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .imm_src   (imm_src),
        .imm       (imm),
        .base      (base),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .instr_hi  (instr_hi),
        .imm_err   (imm_err),
        .err_count (err_count)
    );

    // Reference: write the immediate bits into a full 32-bit word following
    // the format table, base everywhere else.
    function automatic logic [24:0] model_hi(logic [1:0] src, logic [31:0] v, logic [24:0] b);
        logic [31:0] ins;
        ins = {b, 7'b0};
        case (src)
            2'd0: ins[31:20] = v[11:0];
            2'd1: begin
                ins[31:25] = v[11:5];
                ins[11:7]  = v[4:0];
            end
            2'd2: begin
                ins[31]    = v[12];
                ins[30:25] = v[10:5];
                ins[11:8]  = v[4:1];
                ins[7]     = v[11];
            end
            default: begin
                ins[31]    = v[20];
                ins[30:21] = v[10:1];
                ins[20]    = v[11];
                ins[19:12] = v[19:12];
            end
        endcase
        return ins[31:7];
    endfunction

    // Reference: representability as an integer range plus evenness.
    function automatic logic model_err(logic [1:0] src, logic [31:0] v);
        longint s;
        s = longint'($signed(v));
        case (src)
            2'd0, 2'd1: return (s < -2048) || (s > 2047);
            2'd2:       return (s < -4096) || (s > 4095) || v[0];
            default:    return (s < -(64'sd1 <<< 20)) || (s > (64'sd1 <<< 20) - 1) || v[0];
        endcase
    endfunction

    // The immediate extender, used for round-trip checks.
    function automatic logic [31:0] extend(logic [1:0] src, logic [24:0] hi);
        logic [31:0] ins;
        ins = {hi, 7'b0};
        case (src)
            2'd0:    return {{20{ins[31]}}, ins[31:20]};
            2'd1:    return {{20{ins[31]}}, ins[31:25], ins[11:7]};
            2'd2:    return {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            default: return {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        endcase
    endfunction

    function automatic logic [31:0] rand_imm();
        int r;
        logic [31:0] edges [8];
        edges = '{32'h0000_07FF, 32'hFFFF_F800, 32'h0000_0800, 32'h0000_0FFE,
                  32'hFFFF_F000, 32'h000F_FFFE, 32'hFFF0_0000, 32'h0010_0000};
        case ($urandom_range(0, 3))
            0: return $urandom;
            1: begin
                r = int'($urandom_range(0, 10000)) - 5000;
                return r;
            end
            2: begin
                r = int'($urandom_range(0, 32'h40_0000)) - 32'sh20_0000;
                return r;
            end
            default: return edges[$urandom_range(0, 7)];
        endcase
    endfunction

    task automatic test_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        imm_src   = '0;
        imm       = '0;
        base      = '0;
        repeat (3) @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid: got %b want 0", out_valid);
        end
        reset = 1'b0;
        #1;
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || instr_hi !== 25'h0 ||
            imm_err !== 1'b0 || err_count !== 8'h0) begin
            errors++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b hi=%h err=%b cnt=%h want 1 0 0 0 0",
                     in_ready, out_valid, instr_hi, imm_err, err_count);
        end
        m_cnt = 0;
    endtask

    task automatic test_formats();
        logic [1:0]  t_src [6];
        logic [31:0] t_imm [6];
        logic [24:0] t_base[6];
        logic [24:0] t_hi  [6];
        logic        t_err [6];
        t_src  = '{2'd0, 2'd0, 2'd2, 2'd2, 2'd3, 2'd1};
        t_imm  = '{32'hFFFF_F800, 32'd2048, 32'd4094, 32'd3, 32'hFFFF_FFFE, 32'hFFFF_FFE1};
        t_base = '{25'h0, 25'h0, 25'h0, 25'h0, 25'h1, 25'h1FF_FFFF};
        t_hi   = '{25'h100_0000, 25'h100_0000, 25'h0FC_001F, 25'h000_0002, 25'h1FF_FFE1,
                   25'h1FF_FFE1};
        t_err  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            in_valid  = 1'b1;
            out_ready = 1'b1;
            imm_src   = t_src[i];
            imm       = t_imm[i];
            base      = t_base[i];
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            vectors++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL fmt%0d_early: out_valid=%b want 0", i, out_valid);
            end
            @(negedge clk);
            #1;
            vectors++;
            if (out_valid !== 1'b1 || instr_hi !== t_hi[i] || imm_err !== t_err[i]) begin
                errors++;
                $display("FAIL fmt%0d: valid=%b hi=%h err=%b want 1 %h %b",
                         i, out_valid, instr_hi, imm_err, t_hi[i], t_err[i]);
            end
            vectors++;
            if (instr_hi !== model_hi(t_src[i], t_imm[i], t_base[i]) ||
                imm_err !== model_err(t_src[i], t_imm[i])) begin
                errors++;
                $display("FAIL fmt%0d_model: hi=%h err=%b want %h %b", i, instr_hi, imm_err,
                         model_hi(t_src[i], t_imm[i], t_base[i]), model_err(t_src[i], t_imm[i]));
            end
            if (!t_err[i]) begin
                vectors++;
                if (extend(t_src[i], instr_hi) !== t_imm[i]) begin
                    errors++;
                    $display("FAIL fmt%0d_roundtrip: got %h want %h", i,
                             extend(t_src[i], instr_hi), t_imm[i]);
                end
            end
            if (t_err[i] && m_cnt < 255) m_cnt++;
            @(negedge clk);
            #1;
            vectors++;
            if (err_count !== 8'(m_cnt) || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL fmt%0d_count: cnt=%0d valid=%b want %0d 0", i, err_count,
                         out_valid, m_cnt);
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t        reqs[4];
        logic [31:0] r_imm;
        logic [1:0]  r_src;
        logic [24:0] r_base;
        logic [24:0] held_hi;
        logic        held_err;
        int          sent = 0;
        int          recv = 0;
        int          last_recv_cyc = -1;
        bit          dropped = 1'b0;
        for (int i = 0; i < 4; i++) begin
            r_src   = 2'($urandom_range(0, 3));
            r_imm   = $urandom_range(0, 1000) * 2;
            reqs[i] = '{hi: model_hi(r_src, r_imm, 25'h0AA_5555), err: model_err(r_src, r_imm),
                        src: r_src, imm: r_imm};
        end
        for (int cyc = 0; cyc < 20 && recv < 4; cyc++) begin
            @(negedge clk);
            in_valid  = (sent < 4);
            imm_src   = reqs[sent % 4].src;
            imm       = reqs[sent % 4].imm;
            base      = 25'h0AA_5555;
            out_ready = (cyc >= 7);
            #1;
            if (!in_ready && !dropped) begin
                dropped = 1'b1;
                vectors++;
                if (sent != 2) begin
                    errors++;
                    $display("FAIL bp_accepts: in_ready dropped after %0d accepts want 2", sent);
                end
                held_hi  = instr_hi;
                held_err = imm_err;
            end
            if (cyc >= 3 && cyc < 7) begin
                vectors++;
                if (in_ready !== 1'b0 || out_valid !== 1'b1 || instr_hi !== held_hi ||
                    imm_err !== held_err) begin
                    errors++;
                    $display("FAIL bp_hold c%0d: rdy=%b valid=%b hi=%h err=%b want 0 1 %h %b",
                             cyc, in_ready, out_valid, instr_hi, imm_err, held_hi, held_err);
                end
            end
            if (out_valid && out_ready) begin
                vectors++;
                if (instr_hi !== reqs[recv].hi || imm_err !== reqs[recv].err ||
                    (recv > 0 && cyc != last_recv_cyc + 1)) begin
                    errors++;
                    $display("FAIL bp_out%0d: hi=%h err=%b cyc=%0d want %h %b cyc=%0d", recv,
                             instr_hi, imm_err, cyc, reqs[recv].hi, reqs[recv].err,
                             last_recv_cyc + 1);
                end
                if (imm_err && m_cnt < 255) m_cnt++;
                last_recv_cyc = cyc;
                recv++;
            end
            if (in_valid && in_ready) sent++;
        end
        vectors++;
        if (recv != 4) begin
            errors++;
            $display("FAIL bp_drain: received %0d want 4", recv);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_random(input int n, input bit force_err);
        logic [24:0] p_hi;
        logic        p_err;
        logic        p_stall = 1'b0;
        exp_t        e;
        int          k;
        q.delete();
        for (int cyc = 0; cyc < n + 12; cyc++) begin
            @(negedge clk);
            if (cyc < n) begin
                in_valid  = force_err ? 1'b1 : ($urandom_range(0, 3) != 0);
                out_ready = force_err ? 1'b1 : ($urandom_range(0, 3) != 0);
                imm_src   = 2'($urandom_range(0, 3));
                imm       = force_err ? 32'h4000_0001 : rand_imm();
                base      = 25'($urandom);
            end else begin
                in_valid  = 1'b0;
                out_ready = 1'b1;
            end
            #1;
            vectors++;
            if (err_count !== 8'(m_cnt)) begin
                errors++;
                $display("FAIL rnd_count c%0d: got %0d want %0d", cyc, err_count, m_cnt);
            end
            vectors++;
            if (in_ready !== !(out_valid && !out_ready && q.size() == 2)) begin
                errors++;
                $display("FAIL rnd_in_ready c%0d: got %b with %0d in flight", cyc, in_ready,
                         q.size());
            end
            if (p_stall) begin
                vectors++;
                if (out_valid !== 1'b1 || instr_hi !== p_hi || imm_err !== p_err) begin
                    errors++;
                    $display("FAIL rnd_stall c%0d: valid=%b hi=%h err=%b want 1 %h %b", cyc,
                             out_valid, instr_hi, imm_err, p_hi, p_err);
                end
            end
            p_stall = out_valid && !out_ready;
            p_hi    = instr_hi;
            p_err   = imm_err;
            if (out_valid && out_ready) begin
                vectors++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL rnd_spurious c%0d: hi=%h with nothing in flight", cyc,
                             instr_hi);
                end else begin
                    e = q.pop_front();
                    if (instr_hi !== e.hi || imm_err !== e.err) begin
                        errors++;
                        $display("FAIL rnd_data c%0d: hi=%h err=%b want %h %b", cyc, instr_hi,
                                 imm_err, e.hi, e.err);
                    end
                    if (!e.err) begin
                        vectors++;
                        if (extend(e.src, instr_hi) !== e.imm) begin
                            errors++;
                            $display("FAIL rnd_roundtrip c%0d: got %h want %h", cyc,
                                     extend(e.src, instr_hi), e.imm);
                        end
                    end
                end
                if (imm_err && m_cnt < 255) m_cnt++;
            end
            if (in_valid && in_ready) begin
                e = '{hi: model_hi(imm_src, imm, base), err: model_err(imm_src, imm),
                      src: imm_src, imm: imm};
                q.push_back(e);
            end
        end
        k = q.size();
        vectors++;
        if (k != 0) begin
            errors++;
            $display("FAIL rnd_drain: %0d results never emerged", k);
        end
    endtask

    task automatic test_reset_inflight();
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        imm_src   = 2'd0;
        imm       = 32'h0001_0000;
        base      = '0;
        @(negedge clk);
        imm = 32'h0002_0000;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_fill: valid=%b rdy=%b want 1 0", out_valid, in_ready);
        end
        #1;
        reset = 1'b1;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || err_count !== 8'h0) begin
            errors++;
            $display("FAIL rst_async: valid=%b cnt=%0d want 0 0", out_valid, err_count);
        end
        @(negedge clk);
        reset     = 1'b0;
        m_cnt     = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            vectors++;
            if (out_valid !== 1'b0 || err_count !== 8'h0 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL rst_stale c%0d: valid=%b cnt=%0d rdy=%b want 0 0 1", i,
                         out_valid, err_count, in_ready);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_saturation();
        test_random(300, 1'b1);
        #1;
        vectors++;
        if (err_count !== 8'hFF) begin
            errors++;
            $display("FAIL sat_final: got %h want ff", err_count);
        end
    endtask

    initial begin
        test_reset();
        test_formats();
        test_back_to_back();
        test_random(2000, 1'b0);
        test_reset_inflight();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
